// File: rtl/hazard_ctrl.sv
// Hazard/forwarding control: tracks EX/MEM/WB destination info in a shadow pipe,
// stalls on load-use and store-data hazards, registers ALU operand selects for EX.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic        imm_id,
    input  logic        valid_id,
    input  logic        regwr_id,
    input  logic        load_id,
    input  logic [4:0]  rw_id,
    input  logic        flush_ex,
    output logic [1:0]  ALUsrcA,
    output logic [1:0]  ALUsrcB,
    output logic        stall,
    output logic        bubble,
    output logic [15:0] stall_cnt
);
    localparam int STAGES = 3;

    typedef struct packed {
        logic       valid;
        logic       regwr;
        logic       load;
        logic [4:0] rw;
    } shadowEnt_t;

    // [0]=EX, [1]=MEM, [2]=WB
    shadowEnt_t [STAGES-1:0] pipe;
    shadowEnt_t              idEnt;
    logic                    exRs, exRt, memRs, memRt;
    logic                    loadUse, storeData;
    logic [1:0]              selA, selB;
    logic                    unusedWb;

    function automatic logic writes(shadowEnt_t e, logic [4:0] s);
        return e.valid & e.regwr & (e.rw == s) & (s != 5'd0);
    endfunction

    assign idEnt = '{valid: valid_id, regwr: regwr_id, load: load_id, rw: rw_id};

    assign exRs  = writes(pipe[0], rs_id);
    assign exRt  = writes(pipe[0], rt_id);
    assign memRs = writes(pipe[1], rs_id);
    assign memRt = writes(pipe[1], rt_id);

    assign loadUse   = pipe[0].load & ((use_rs_id & exRs) | (use_rt_id & ~imm_id & exRt));
    // Immediate occupies operand B, so the store data has no forwarding path
    assign storeData = imm_id & use_rt_id & (exRt | memRt);

    assign stall  = (loadUse | storeData) & valid_id & ~flush_ex;
    assign bubble = stall | flush_ex | ~valid_id;

    always_comb begin
        selA = 2'b00;
        if (use_rs_id) begin
            if (exRs)       selA = 2'b01;
            else if (memRs) selA = 2'b10;
        end
        selB = 2'b00;
        if (imm_id)         selB = 2'b11;
        else if (use_rt_id) begin
            if (exRt)       selB = 2'b01;
            else if (memRt) selB = 2'b10;
        end
    end

    // WB slot is tracked but never forwarded from: the regfile writes before reads
    assign unusedWb = ^{pipe[STAGES-1], pipe[1].load};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe      <= '0;
            ALUsrcA   <= 2'b00;
            ALUsrcB   <= 2'b00;
            stall_cnt <= 16'd0;
        end else begin
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            pipe[0] <= bubble ? '0 : idEnt;
            ALUsrcA <= bubble ? 2'b00 : selA;
            ALUsrcB <= bubble ? 2'b00 : selB;
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule
